mul_acc_stage: RTL and testbench

Downstream accumulation stage for the Int_ALU 4-bit multiplier. It consumes one 4-bit PRODUCT plus its carry_out per beat. Each beat is weighted by a nibble position and summed into an ACC_W-bit accumulator. The finished sum is presented on a valid/ready output. This is how the team builds wide partial-product sums from the narrow multiplier.

---
 rtl/mul_acc_stage_if.sv | 27 ++
 rtl/mul_acc_stage.sv | 99 +++++++++
 tb/tb_mul_acc_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mul_acc_stage_if.sv
// Beat and result handshake bundle for mul_acc_stage.
// master = upstream/downstream side, slave = the accumulation stage.
interface mul_acc_stage_if #(
  parameter int ACC_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       product;
  logic             carry_in;
  logic [1:0]       shift;
  logic             last;
  logic             clear;
  logic [ACC_W-1:0] acc;
  logic             overflow;
  logic             acc_valid;
  logic             acc_ready;

  modport master (
    output in_valid, product, carry_in, shift, last, clear, acc_ready,
    input  in_ready, acc, overflow, acc_valid
  );

  modport slave (
    input  in_valid, product, carry_in, shift, last, clear, acc_ready,
    output in_ready, acc, overflow, acc_valid
  );
endinterface

// File: rtl/mul_acc_stage.sv
// Nibble-weighted accumulator for the 4-bit multiplier's PRODUCT/carry_out beats.
// Define MUL_ACC_SAT_EN to saturate acc on overflow instead of wrapping.
//
// state | meaning
// ------+--------------------------------------------
// IDLE  | acc == 0, no beats taken for this sum yet
// ACCUM | partial sum held, more beats expected
// HOLD  | sum complete, waiting for acc_ready
module mul_acc_stage #(
  parameter int ACC_W = 16
) (
  input logic           clk,
  input logic           rst,
  mul_acc_stage_if.slave bus
);
  localparam int SUM_W = ACC_W + 17;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             acc_valid_q;

  logic             accept;
  logic [16:0]      term;
  logic [ACC_W-1:0] base;
  logic [SUM_W-1:0] sum;
  logic             lost;
  logic             next_ovf;
  logic [ACC_W-1:0] next_acc;

  // clear zeroes the base before the add, so a cleared beat contributes alone
  always_comb begin
    accept   = bus.in_valid && in_ready_q;
    term     = 17'({bus.carry_in, bus.product}) << {bus.shift, 2'b00};
    base     = bus.clear ? '0 : acc_q;
    sum      = SUM_W'(base) + SUM_W'(term);
    lost     = |sum[SUM_W-1:ACC_W];
    next_ovf = (bus.clear ? 1'b0 : ovf_q) | lost;
`ifdef MUL_ACC_SAT_EN
    next_acc = next_ovf ? '1 : sum[ACC_W-1:0];
`else
    next_acc = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      acc_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_q <= next_acc;
            ovf_q <= next_ovf;
            if (bus.last) begin
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              acc_valid_q <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end else if (bus.clear) begin
            state <= IDLE;
            acc_q <= '0;
            ovf_q <= 1'b0;
          end
        end
        HOLD: begin
          if (bus.acc_ready) begin
            state       <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            acc_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          acc_q       <= '0;
          ovf_q       <= 1'b0;
          in_ready_q  <= 1'b1;
          acc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.acc_valid = acc_valid_q;
  assign bus.acc       = acc_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_mul_acc_stage.sv
// Directed bench for mul_acc_stage: vector table plus back-pressure and reset sequences.
module tb_mul_acc_stage;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mul_acc_stage_if #(.ACC_W(16)) bus ();

  mul_acc_stage #(.ACC_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        v;
    logic [3:0]  p;
    logic        c;
    logic [1:0]  s;
    logic        l;
    logic        clr;
    logic        ar;
    logic [15:0] e_acc;
    logic        e_ovf;
    logic        e_av;
    logic        e_ir;
  } vec_t;

  vec_t vecs[$];

`ifdef MUL_ACC_SAT_EN
  localparam logic [15:0] OVF_TWO_F  = 16'hFFFF;
  localparam logic [15:0] OVF_1F     = 16'hFFFF;
  localparam logic [15:0] OVF_1F_P1  = 16'hFFFF;
`else
  localparam logic [15:0] OVF_TWO_F  = 16'hE000;
  localparam logic [15:0] OVF_1F     = 16'hF000;
  localparam logic [15:0] OVF_1F_P1  = 16'hF001;
`endif

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] p, input logic c,
                       input logic [1:0] s, input logic l, input logic clr,
                       input logic ar);
    bus.in_valid  = v;
    bus.product   = p;
    bus.carry_in  = c;
    bus.shift     = s;
    bus.last      = l;
    bus.clear     = clr;
    bus.acc_ready = ar;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input int idx, input logic [15:0] e_acc,
                         input logic e_ovf, input logic e_av, input logic e_ir);
    chk({name, ".acc"}, idx, 32'(bus.acc), 32'(e_acc));
    chk({name, ".overflow"}, idx, 32'(bus.overflow), 32'(e_ovf));
    chk({name, ".acc_valid"}, idx, 32'(bus.acc_valid), 32'(e_av));
    chk({name, ".in_ready"}, idx, 32'(bus.in_ready), 32'(e_ir));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //               v  p     c  s  l  clr ar  acc         ovf av ir
    vecs.push_back('{1, 4'h6, 0, 0, 0, 0, 0, 16'h0006,   0, 0, 1});
    vecs.push_back('{1, 4'h2, 1, 1, 1, 0, 0, 16'h0126,   0, 1, 0});
    vecs.push_back('{0, 4'h0, 0, 0, 0, 0, 1, 16'h0000,   0, 0, 1});
    vecs.push_back('{1, 4'hF, 0, 3, 0, 0, 0, 16'hF000,   0, 0, 1});
    vecs.push_back('{1, 4'hF, 0, 3, 1, 0, 0, OVF_TWO_F,  1, 1, 0});
    vecs.push_back('{1, 4'h1, 0, 0, 0, 0, 0, OVF_TWO_F,  1, 1, 0});
    vecs.push_back('{0, 4'h0, 0, 0, 0, 0, 1, 16'h0000,   0, 0, 1});
    vecs.push_back('{1, 4'h4, 0, 1, 0, 0, 0, 16'h0040,   0, 0, 1});
    vecs.push_back('{1, 4'h3, 0, 0, 0, 1, 0, 16'h0003,   0, 0, 1});
    vecs.push_back('{0, 4'h0, 0, 0, 0, 1, 0, 16'h0000,   0, 0, 1});
    vecs.push_back('{1, 4'hF, 1, 3, 0, 0, 0, OVF_1F,     1, 0, 1});
    vecs.push_back('{1, 4'h1, 0, 0, 0, 1, 0, 16'h0001,   0, 0, 1});
    vecs.push_back('{1, 4'h2, 0, 2, 1, 0, 0, 16'h0201,   0, 1, 0});
    vecs.push_back('{0, 4'h0, 0, 0, 0, 1, 0, 16'h0201,   0, 1, 0});
    vecs.push_back('{0, 4'h0, 0, 0, 0, 0, 1, 16'h0000,   0, 0, 1});
    vecs.push_back('{0, 4'h9, 1, 2, 1, 0, 0, 16'h0000,   0, 0, 1});
    vecs.push_back('{1, 4'hF, 1, 3, 0, 0, 0, OVF_1F,     1, 0, 1});
    vecs.push_back('{1, 4'h1, 0, 0, 0, 0, 0, OVF_1F_P1,  1, 0, 1});
    vecs.push_back('{1, 4'h0, 0, 0, 1, 0, 0, OVF_1F_P1,  1, 1, 0});
    vecs.push_back('{0, 4'h0, 0, 0, 0, 0, 1, 16'h0000,   0, 0, 1});

    // Reset: in_valid high during the second reset cycle must not load a beat
    rst = 1'b1;
    drive(0, 4'h0, 0, 0, 0, 0, 0);
    step();
    drive(1, 4'hF, 1, 3, 0, 0, 0);
    step();
    chk_all("reset", 0, 16'h0000, 0, 0, 1);
    rst = 1'b0;
    drive(0, 4'h0, 0, 0, 0, 0, 0);
    step();
    chk_all("reset", 1, 16'h0000, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].p, vecs[i].c, vecs[i].s, vecs[i].l, vecs[i].clr,
            vecs[i].ar);
      step();
      chk_all("vec", i, vecs[i].e_acc, vecs[i].e_ovf, vecs[i].e_av, vecs[i].e_ir);
    end

    // Back-pressure: sum held while upstream keeps a beat pending
    drive(1, 4'h5, 0, 0, 1, 0, 0);
    step();
    chk_all("bp_last", 0, 16'h0005, 0, 1, 0);
    drive(1, 4'h7, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all("bp_hold", i, 16'h0005, 0, 1, 0);
    end
    drive(1, 4'h7, 0, 0, 0, 0, 1);
    step();
    chk_all("bp_release", 0, 16'h0000, 0, 0, 1);
    drive(1, 4'h7, 0, 0, 0, 0, 0);
    step();
    chk_all("bp_held_beat", 0, 16'h0007, 0, 0, 1);
    drive(0, 4'h0, 0, 0, 0, 1, 0);
    step();
    chk_all("bp_clear", 0, 16'h0000, 0, 0, 1);

    // Reset mid-sum drops the partial sum
    drive(1, 4'h1, 0, 0, 0, 0, 0);
    step();
    drive(1, 4'h2, 0, 0, 0, 0, 0);
    step();
    chk_all("rst_mid_pre", 0, 16'h0003, 0, 0, 1);
    rst = 1'b1;
    drive(1, 4'h4, 0, 0, 0, 0, 0);
    step();
    chk_all("rst_mid", 0, 16'h0000, 0, 0, 1);
    rst = 1'b0;
    drive(0, 4'h0, 0, 0, 0, 0, 0);
    step();
    chk_all("rst_mid_after", 0, 16'h0000, 0, 0, 1);

    // Reset while holding a completed sum
    drive(1, 4'h8, 0, 1, 1, 0, 0);
    step();
    chk_all("rst_hold_pre", 0, 16'h0080, 0, 1, 0);
    rst = 1'b1;
    drive(0, 4'h0, 0, 0, 0, 0, 0);
    step();
    chk_all("rst_hold", 0, 16'h0000, 0, 0, 1);
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
